// File: rtl/haz_pkg.sv
// -----------------------------------------------------------------------------
// haz_pkg
// Shared definitions for the pipeline hazard/stall controller:
//   - haz_state_e : data-cache miss freeze FSM states (RUN, MISS, RESUME)
//   - FWD_*       : EX-stage operand forwarding select encodings
//   - sat_inc8    : saturating 8-bit increment used by the miss-wait counter
// -----------------------------------------------------------------------------
package haz_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_MISS   = 2'b01,
    ST_RESUME = 2'b10
  } haz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // Increment that sticks at 8'hFF instead of wrapping back to zero.
  function automatic logic [7:0] sat_inc8(input logic [7:0] i_val);
    logic [7:0] w_res;
    if (i_val == 8'hFF) begin
      w_res = i_val;
    end else begin
      w_res = i_val + 8'd1;
    end
    return w_res;
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// -----------------------------------------------------------------------------
// hazard_fwd_unit
// Purely combinational forwarding compare for one EX-stage source operand.
// The MEM-stage producer wins over the WB-stage producer because it holds the
// younger value of the register.
// Ports:
//   i_rs          EX source register number
//   i_use         EX instruction actually reads this operand
//   i_rd_m        MEM destination register
//   i_regwrite_m  MEM write-enable group (nonzero = writes register file)
//   i_rd_w        WB destination register
//   i_regwrite_w  WB write-enable group (nonzero = writes register file)
//   o_sel         FWD_RF / FWD_MEM / FWD_WB
// -----------------------------------------------------------------------------
module hazard_fwd_unit
  import haz_pkg::*;
(
  input  logic [4:0] i_rs,
  input  logic       i_use,
  input  logic [4:0] i_rd_m,
  input  logic [2:0] i_regwrite_m,
  input  logic [4:0] i_rd_w,
  input  logic [2:0] i_regwrite_w,
  output logic [1:0] o_sel
);

  logic w_hit_m;
  logic w_hit_w;

  // x0 is hard-wired to zero, so a producer targeting it never forwards.
  assign w_hit_m = i_use && (i_regwrite_m != 3'b000) && (i_rd_m != 5'd0) && (i_rd_m == i_rs);
  assign w_hit_w = i_use && (i_regwrite_w != 3'b000) && (i_rd_w != 5'd0) && (i_rd_w == i_rs);

  // Select with MEM priority over WB.
  always_comb begin
    o_sel = FWD_RF;
    if (w_hit_m) begin
      o_sel = FWD_MEM;
    end else if (w_hit_w) begin
      o_sel = FWD_WB;
    end else begin
      o_sel = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Hazard and stall controller for the 5-stage RISC-V pipeline. Produces the
// segment-register stall (en = ~Stall*) and flush (clear = Flush*) controls,
// the EX operand forwarding selects, and runs the data-cache miss freeze FSM
// with a req/ack refill handshake.
//
// Optional feature macro: HAZ_PERF_CNT_EN adds PERF_W-bit wrap-around
// performance counters (perf_stall_cyc, perf_mispred, perf_miss).
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   Rs1D, Rs2D, RegReadD        ID sources and read usage ([1]=rs1, [0]=rs2)
//   Rs1E, Rs2E, RdE, RegReadE   EX register fields and read usage
//   MemToRegE                   EX instruction is a load
//   RdM, RdW, RegWriteM/W       MEM/WB destinations and write enables
//   JalD, MispredE              control-flow redirects
//   DMissM, mem_ack             data-cache miss and refill completion
//   mem_req                     registered refill request
//   StallF..StallW, FlushD..W   segment-register controls
//   Forward1E, Forward2E        forwarding selects
//   miss_timeout                sticky refill-timeout flag
// -----------------------------------------------------------------------------
module hazard_ctrl
  import haz_pkg::*;
#(
  parameter logic [7:0] MISS_MAX = 8'd255
`ifdef HAZ_PERF_CNT_EN
  ,
  parameter int PERF_W = 32
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [1:0]  RegReadD,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [1:0]  RegReadE,
  input  logic        MemToRegE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic [2:0]  RegWriteM,
  input  logic [2:0]  RegWriteW,
  input  logic        JalD,
  input  logic        MispredE,
  input  logic        DMissM,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        StallW,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushM,
  output logic        FlushW,
  output logic [1:0]  Forward1E,
  output logic [1:0]  Forward2E,
`ifdef HAZ_PERF_CNT_EN
  output logic [PERF_W-1:0] perf_stall_cyc,
  output logic [PERF_W-1:0] perf_mispred,
  output logic [PERF_W-1:0] perf_miss,
`endif
  output logic        miss_timeout
);

  haz_state_e r_state;
  haz_state_e w_state_nxt;
  logic       r_mem_req;
  logic [7:0] r_miss_cnt;
  logic       r_timeout;

  logic       w_miss_enter;
  logic       w_in_miss;
  logic       w_miss_stall;
  logic       w_load_use;
  logic [7:0] w_cnt_inc;

  // DMissM only starts a miss from RUN; in RESUME it still shows the retiring
  // access and must not re-trigger the freeze.
  assign w_miss_enter = (r_state == ST_RUN) && DMissM;
  assign w_in_miss    = (r_state == ST_MISS);
  assign w_miss_stall = w_miss_enter || (w_in_miss && !mem_ack);
  assign w_cnt_inc    = sat_inc8(r_miss_cnt);

  // A load in EX whose destination is read by the instruction in ID.
  assign w_load_use = MemToRegE && (RdE != 5'd0) &&
                      (((RdE == Rs1D) && RegReadD[1]) || ((RdE == Rs2D) && RegReadD[0]));

  // Miss FSM next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (DMissM) begin
          w_state_nxt = ST_MISS;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_MISS: begin
        if (mem_ack) begin
          w_state_nxt = ST_RESUME;
        end else begin
          w_state_nxt = ST_MISS;
        end
      end
      ST_RESUME: w_state_nxt = ST_RUN;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  // Miss FSM state register; reset aborts any refill in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Refill request: raised on entry to MISS, dropped on the edge that sees ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_req <= 1'b0;
    end else if (w_miss_enter) begin
      r_mem_req <= 1'b1;
    end else if (w_in_miss && mem_ack) begin
      r_mem_req <= 1'b0;
    end else begin
      r_mem_req <= r_mem_req;
    end
  end

  // Miss-wait counter: restarts at miss entry, counts every MISS cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miss_cnt <= 8'd0;
    end else if (w_miss_enter) begin
      r_miss_cnt <= 8'd0;
    end else if (w_in_miss) begin
      r_miss_cnt <= w_cnt_inc;
    end else begin
      r_miss_cnt <= r_miss_cnt;
    end
  end

  // Sticky timeout: set on the edge where the count goes past MISS_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timeout <= 1'b0;
    end else if (w_in_miss && (w_cnt_inc > MISS_MAX)) begin
      r_timeout <= 1'b1;
    end else begin
      r_timeout <= r_timeout;
    end
  end

  assign mem_req      = r_mem_req;
  assign miss_timeout = r_timeout;

  // Stall/flush priority: reset, miss freeze, mispredict, jal, load-use.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    StallW = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    FlushW = 1'b0;
    if (!rst_n) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushM = 1'b1;
      FlushW = 1'b1;
    end else if (w_miss_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      StallW = 1'b1;
    end else if (MispredE) begin
      // The ID instruction is squashed too, so any load-use on it is moot.
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (JalD) begin
      FlushD = 1'b1;
    end else if (w_load_use) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else begin
      StallF = 1'b0;
    end
  end

  hazard_fwd_unit u_fwd1 (
    .i_rs         (Rs1E),
    .i_use        (RegReadE[1]),
    .i_rd_m       (RdM),
    .i_regwrite_m (RegWriteM),
    .i_rd_w       (RdW),
    .i_regwrite_w (RegWriteW),
    .o_sel        (Forward1E)
  );

  hazard_fwd_unit u_fwd2 (
    .i_rs         (Rs2E),
    .i_use        (RegReadE[0]),
    .i_rd_m       (RdM),
    .i_regwrite_m (RegWriteM),
    .i_rd_w       (RdW),
    .i_regwrite_w (RegWriteW),
    .o_sel        (Forward2E)
  );

`ifdef HAZ_PERF_CNT_EN
  logic [PERF_W-1:0] r_perf_stall;
  logic [PERF_W-1:0] r_perf_mispred;
  logic [PERF_W-1:0] r_perf_miss;

  // Performance counters; each wraps naturally at 2**PERF_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall   <= '0;
      r_perf_mispred <= '0;
      r_perf_miss    <= '0;
    end else begin
      if (StallF) begin
        r_perf_stall <= r_perf_stall + 1'b1;
      end else begin
        r_perf_stall <= r_perf_stall;
      end
      if (MispredE && !w_miss_stall) begin
        r_perf_mispred <= r_perf_mispred + 1'b1;
      end else begin
        r_perf_mispred <= r_perf_mispred;
      end
      if (w_miss_enter) begin
        r_perf_miss <= r_perf_miss + 1'b1;
      end else begin
        r_perf_miss <= r_perf_miss;
      end
    end
  end

  assign perf_stall_cyc = r_perf_stall;
  assign perf_mispred   = r_perf_mispred;
  assign perf_miss      = r_perf_miss;
`endif

endmodule
